// File: rtl/logic_gate_unit_pkg.sv
// Shared definitions for the bitwise gate unit: result-select encoding.
package logic_gate_unit_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_NAND = 2'b01,
    OP_INV  = 2'b10,
    OP_RSVD = 2'b11
  } gate_op_e;

endpackage

// File: rtl/logic_gate_unit_gate_bit_slice.sv
// One bit of the gate unit: AND, NAND and INVERT of a single operand pair.
module gate_bit_slice (
  input  logic a,
  input  logic b,
  output logic and_o,
  output logic nand_o,
  output logic inv_o
);

  assign and_o  = a & b;
  assign nand_o = ~(a & b);
  assign inv_o  = ~a;

endmodule

// File: rtl/logic_gate_unit.sv
// Bitwise AND/NAND/INVERT unit: combinational results plus an op-selected,
// one-cycle registered result with an aligned valid flag.
module logic_gate_unit
  import logic_gate_unit_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in_1,
  input  logic [WIDTH-1:0] data_in_2,
  input  logic [1:0]       op,
  input  logic             valid_in,
  output logic [WIDTH-1:0] and_out,
  output logic [WIDTH-1:0] nand_out,
  output logic [WIDTH-1:0] inv_out,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    gate_bit_slice u_slice (
      .a      (data_in_1[i]),
      .b      (data_in_2[i]),
      .and_o  (and_out[i]),
      .nand_o (nand_out[i]),
      .inv_o  (inv_out[i])
    );
  end

  logic [WIDTH-1:0] sel_res;
  logic [WIDTH-1:0] data_d, data_q;
  logic             valid_d, valid_q;

  // Reserved encoding deliberately yields all-zeros rather than X.
  always_comb begin
    sel_res = '0;
    case (op)
      OP_AND:  sel_res = and_out;
      OP_NAND: sel_res = nand_out;
      OP_INV:  sel_res = inv_out;
      default: sel_res = '0;
    endcase
  end

  always_comb begin
    valid_d = valid_in;
    data_d  = valid_in ? sel_res : data_q;
  end

  // Stage boundary: capture selected result; reset overrides any pending capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Scoreboard bench for logic_gate_unit: WIDTH=8 pipelined checks plus two
// WIDTH=1 instances for reset, exhaustive truth and composite-function checks.
module tb_logic_gate_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       rst8, vld8;
  logic [1:0] op8;
  logic [7:0] a8, b8;
  logic [7:0] and8, nand8, inv8, dout8;
  logic       vout8;

  logic_gate_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst8), .data_in_1(a8), .data_in_2(b8), .op(op8),
    .valid_in(vld8), .and_out(and8), .nand_out(nand8), .inv_out(inv8),
    .data_out(dout8), .valid_out(vout8)
  );

  // WIDTH=1 instances; the second ANDs ~a (from the first) with c
  logic       rst1, vld1;
  logic [1:0] op1;
  logic [0:0] a1, b1, c2;
  logic [0:0] and1, nand1, inv1, dout1;
  logic       vout1;
  logic [0:0] and2, nand2, inv2, dout2;
  logic       vout2;

  logic_gate_unit #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst1), .data_in_1(a1), .data_in_2(b1), .op(op1),
    .valid_in(vld1), .and_out(and1), .nand_out(nand1), .inv_out(inv1),
    .data_out(dout1), .valid_out(vout1)
  );

  logic_gate_unit #(.WIDTH(1)) u_dut2 (
    .clk(clk), .rst(rst1), .data_in_1(inv1), .data_in_2(c2), .op(2'b00),
    .valid_in(1'b0), .and_out(and2), .nand_out(nand2), .inv_out(inv2),
    .data_out(dout2), .valid_out(vout2)
  );

  typedef struct {
    bit         v;
    logic [7:0] d;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mdl_d;
  int         n_vec = 0;
  int         n_err = 0;

  // Per-bit truth tables indexed by {a,b}
  localparam logic [3:0] AND_TT  = 4'b1000;
  localparam logic [3:0] NAND_TT = 4'b0111;

  function automatic logic [7:0] gate_ref(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [3:0] and_tt;
    logic [3:0] nand_tt;
    and_tt  = AND_TT;
    nand_tt = NAND_TT;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      case (o)
        2'd0:    r[i] = and_tt[{a[i], b[i]}];
        2'd1:    r[i] = nand_tt[{a[i], b[i]}];
        2'd2:    r[i] = (a[i] == 1'b0);
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Drive one cycle of WIDTH=8 stimulus and queue the response due after the next edge.
  task automatic step8(input bit r, input bit v, input logic [1:0] o,
                       input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    rst8 = r; vld8 = v; op8 = o; a8 = a; b8 = b;
    if (r) begin
      mdl_d = 8'h00;
      e.v   = 1'b0;
    end else begin
      e.v = v;
      if (v) mdl_d = gate_ref(o, a, b);
    end
    e.d = mdl_d;
    exp_q.push_back(e);
  endtask

  task automatic chk_comb8();
    #1;
    chk("and8",  and8,  gate_ref(2'd0, a8, b8));
    chk("nand8", nand8, gate_ref(2'd1, a8, b8));
    chk("inv8",  inv8,  gate_ref(2'd2, a8, b8));
  endtask

  // Monitor: pops one expectation per clock edge that stimulus queued for.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("valid_out", vout8, e.v);
      if (e.v) chk("data_out", dout8, e.d);
      else if (vout8 === 1'b0) chk("data_out_hold", dout8, e.d);
    end
  end

  initial begin
    logic [2:0] iv;
    logic       ea, eb, ec;
    rst1 = 1'b1; vld1 = 1'b1; op1 = 2'b00; a1 = 1'b1; b1 = 1'b1; c2 = 1'b0;
    rst8 = 1'b1; vld8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
    mdl_d = '0;

    // Reset with a pending capture on the WIDTH=1 unit
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      rst1 = 1'b1; vld1 = 1'b1; op1 = 2'b00; a1 = 1'b1; b1 = 1'b1;
      step8(1'b1, 1'b1, 2'b00, 8'hFF, 8'hFF);
      @(posedge clk); #2;
      chk("rst_data1", dout1, 1'b0);
      chk("rst_valid1", vout1, 1'b0);
      chk("rst_and1", and1, 1'b1);
    end
    @(negedge clk);
    rst1 = 1'b0; vld1 = 1'b0;
    step8(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);

    // Exhaustive WIDTH=1 truth
    for (int k = 0; k < 4; k++) begin
      iv = 3'(k);
      a1 = iv[1]; b1 = iv[0];
      #1;
      chk("tt_and",  and1,  {1'b0, AND_TT}  >> k & 5'd1);
      chk("tt_nand", nand1, {1'b0, NAND_TT} >> k & 5'd1);
      chk("tt_inv",  inv1,  (iv[1] == 1'b0));
    end

    // Registered ops on C5/3F, back to back
    @(negedge clk); step8(1'b0, 1'b1, 2'b00, 8'hC5, 8'h3F); chk_comb8();
    @(negedge clk); step8(1'b0, 1'b1, 2'b01, 8'hC5, 8'h3F); chk_comb8();
    @(negedge clk); step8(1'b0, 1'b1, 2'b10, 8'hC5, 8'h3F); chk_comb8();
    // Bubbles: inputs wander, data_out must hold the INV result
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      step8(1'b0, 1'b0, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      chk_comb8();
    end
    @(posedge clk); #2;
    chk("hold_3A", dout8, 8'h3A);

    // Reserved op, then reset colliding with a capture
    @(negedge clk); step8(1'b0, 1'b1, 2'b11, 8'hFF, 8'hFF);
    @(negedge clk); step8(1'b1, 1'b1, 2'b00, 8'hFF, 8'hFF);
    @(negedge clk); step8(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      step8(($urandom_range(0, 15) == 0), 1'($urandom), 2'($urandom_range(0, 3)),
            8'($urandom), 8'($urandom));
      chk_comb8();
    end
    @(negedge clk); step8(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);

    // Composite (a&b) | (~a&c) from two WIDTH=1 units
    for (int k = 0; k < 8; k++) begin
      iv = 3'(k);
      a1 = iv[0]; b1 = iv[1]; c2 = iv[2];
      #1;
      ea = iv[0]; eb = iv[1]; ec = iv[2];
      chk("composite", and1 | and2, (ea && eb) || (!ea && ec));
    end

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #3;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
